// File: rtl/ps_pl_platform_wrapper.sv
`default_nettype none
// ============================================================================
// Module   : ps_pl_platform_wrapper
// Purpose  : PL platform glue between the processor register bus, a
//            CDMA-style word copy engine, a local coefficient BRAM and the
//            control/status registers of an external NTT core.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   ACLK, ARESET          clock, asynchronous active-high reset
//   reg_req/we/addr/wdata register bus request (one-cycle pulse)
//   reg_ack/rdata         acknowledge one cycle after request, read data
//   ddr_req/we/addr/wdata DDR word request, held until ddr_ack
//   ddr_ack/rdata         DDR acknowledge with same-cycle read data
//   ntt_start/mode        start pulse and NTT/iNTT select for the core
//   ntt_done              done pulse from the core
//   ntt_mem_*             core-side BRAM port (owned by the core while busy)
//   irq[1:0]              [0] NTT done, [1] CDMA
// ============================================================================
module ps_pl_platform_wrapper #(
    parameter int          NTT_SIZE      = 256,
    parameter logic [31:0] NTT_CTRL_BASE = 32'h43C0_0000,
    parameter logic [31:0] NTT_DATA_BASE = 32'h7600_0000,
    parameter logic [31:0] CDMA_BASE     = 32'h7E20_0000
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic        reg_req,
    input  logic        reg_we,
    input  logic [31:0] reg_addr,
    input  logic [31:0] reg_wdata,
    output logic        reg_ack,
    output logic [31:0] reg_rdata,
    output logic        ddr_req,
    output logic        ddr_we,
    output logic [31:0] ddr_addr,
    output logic [31:0] ddr_wdata,
    input  logic        ddr_ack,
    input  logic [31:0] ddr_rdata,
    output logic        ntt_start,
    output logic        ntt_mode,
    input  logic        ntt_done,
    input  logic        ntt_mem_en,
    input  logic        ntt_mem_we,
    input  logic [7:0]  ntt_mem_addr,
    input  logic [31:0] ntt_mem_wdata,
    output logic [31:0] ntt_mem_rdata,
    output logic [1:0]  irq
);

    localparam int          c_AW        = $clog2(NTT_SIZE);
    localparam logic [32:0] c_WIN_BYTES = 33'(NTT_SIZE * 4);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_CHECK = 3'd1;
    localparam logic [2:0] c_ST_RD    = 3'd2;
    localparam logic [2:0] c_ST_WR    = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;
    localparam logic [2:0] c_ST_ERR   = 3'd5;

    function automatic logic in_win(input logic [31:0] a);
        return ({1'b0, a} >= {1'b0, NTT_DATA_BASE}) &&
               (({1'b0, a} - {1'b0, NTT_DATA_BASE}) < c_WIN_BYTES);
    endfunction

    function automatic logic [c_AW-1:0] win_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - NTT_DATA_BASE;
        return off[c_AW+1:2];
    endfunction

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [31:0] r_mem [NTT_SIZE];

    logic        r_ack;
    logic [31:0] r_rdata;
    logic        r_ntt_busy, r_ntt_done, r_ntt_err, r_ntt_mode;
    logic        r_start_pend, r_ntt_start;
    logic        r_cr_ioc_en, r_cr_err_en;
    logic        r_sr_ioc, r_sr_slverr, r_sr_errirq;
    logic [31:0] r_sa, r_da;
    logic [22:0] r_btt;
    logic        r_btt_ntt_busy;      // NTT state sampled when BTT was written
    logic [2:0]  r_state, w_next;
    logic [31:0] r_src, r_dst, r_data;
    logic [20:0] r_left;

    // ------------------------------------------------------------------
    // Register bus decode
    // ------------------------------------------------------------------
    logic w_wr, w_rd;
    logic w_hit_ctrl, w_hit_stat, w_hit_cr, w_hit_sr, w_hit_sa, w_hit_da, w_hit_btt, w_hit_bram;
    logic w_soft_rst, w_eng_idle;
    logic [31:0] w_mem_rd_reg;

    assign w_wr       = reg_req & reg_we;
    assign w_rd       = reg_req & ~reg_we;
    assign w_hit_ctrl = (reg_addr == NTT_CTRL_BASE);
    assign w_hit_stat = (reg_addr == NTT_CTRL_BASE + 32'h04);
    assign w_hit_cr   = (reg_addr == CDMA_BASE);
    assign w_hit_sr   = (reg_addr == CDMA_BASE + 32'h04);
    assign w_hit_sa   = (reg_addr == CDMA_BASE + 32'h18);
    assign w_hit_da   = (reg_addr == CDMA_BASE + 32'h20);
    assign w_hit_btt  = (reg_addr == CDMA_BASE + 32'h28);
    assign w_hit_bram = in_win(reg_addr);
    assign w_soft_rst = w_wr & w_hit_cr & reg_wdata[2];
    assign w_eng_idle = (r_state == c_ST_IDLE);
    assign w_mem_rd_reg = r_mem[win_idx(reg_addr)];

    // ------------------------------------------------------------------
    // Engine qualifiers
    // ------------------------------------------------------------------
    logic        w_src_bram, w_dst_bram, w_rd_done, w_wr_done, w_last;
    logic        w_chk_err, w_ioc_set, w_err_set, w_eng_mem_we;
    logic [32:0] w_sa_off, w_da_off;

    assign w_src_bram = in_win(r_src);
    assign w_dst_bram = in_win(r_dst);
    // BRAM steps stall while the NTT core owns the port
    assign w_rd_done  = w_src_bram ? ~r_ntt_busy : ddr_ack;
    assign w_wr_done  = w_dst_bram ? ~r_ntt_busy : ddr_ack;
    assign w_last     = (r_left == 21'd1);
    assign w_sa_off   = {1'b0, r_sa} - {1'b0, NTT_DATA_BASE};
    assign w_da_off   = {1'b0, r_da} - {1'b0, NTT_DATA_BASE};

    // All error causes are evaluated against SA/DA/BTT before the first word
    assign w_chk_err  = (r_btt == 23'd0) || (r_btt[1:0] != 2'b00) || r_btt_ntt_busy ||
                        (in_win(r_sa) && ((w_sa_off + {10'b0, r_btt}) > c_WIN_BYTES)) ||
                        (in_win(r_da) && ((w_da_off + {10'b0, r_btt}) > c_WIN_BYTES));
    assign w_ioc_set  = (r_state == c_ST_WR) & w_wr_done & w_last & ~w_soft_rst;
    assign w_err_set  = (r_state == c_ST_CHECK) & w_chk_err & ~w_soft_rst;

    // ------------------------------------------------------------------
    // Engine FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) r_state <= c_ST_IDLE;
        else        r_state <= w_next;
    end

    // Engine FSM: next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_wr & w_hit_btt) w_next = c_ST_CHECK;
            c_ST_CHECK: w_next = w_chk_err ? c_ST_ERR : c_ST_RD;
            c_ST_RD:    if (w_rd_done) w_next = c_ST_WR;
            c_ST_WR:    if (w_wr_done) w_next = w_last ? c_ST_DONE : c_ST_RD;
            default:    w_next = c_ST_IDLE;
        endcase
        if (w_soft_rst) w_next = c_ST_IDLE;
    end

    // Engine FSM: outputs
    always_comb begin
        ddr_req      = 1'b0;
        ddr_we       = 1'b0;
        ddr_addr     = 32'd0;
        ddr_wdata    = 32'd0;
        w_eng_mem_we = 1'b0;
        case (r_state)
            c_ST_RD: begin
                if (!w_src_bram) begin
                    ddr_req  = 1'b1;
                    ddr_addr = r_src;
                end
            end
            c_ST_WR: begin
                if (!w_dst_bram) begin
                    ddr_req   = 1'b1;
                    ddr_we    = 1'b1;
                    ddr_addr  = r_dst;
                    ddr_wdata = r_data;
                end else begin
                    w_eng_mem_we = ~r_ntt_busy & ~w_soft_rst;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Engine datapath
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_src  <= 32'd0;
            r_dst  <= 32'd0;
            r_data <= 32'd0;
            r_left <= 21'd0;
        end else if (w_soft_rst) begin
            r_src  <= 32'd0;
            r_dst  <= 32'd0;
            r_data <= 32'd0;
            r_left <= 21'd0;
        end else begin
            case (r_state)
                c_ST_CHECK: begin
                    r_src  <= r_sa;
                    r_dst  <= r_da;
                    r_left <= r_btt[22:2];
                end
                c_ST_RD: begin
                    if (w_rd_done) begin
                        r_data <= w_src_bram ? r_mem[win_idx(r_src)] : ddr_rdata;
                        r_src  <= r_src + 32'd4;
                    end
                end
                c_ST_WR: begin
                    if (w_wr_done) begin
                        r_dst  <= r_dst + 32'd4;
                        r_left <= r_left - 21'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Register file, NTT control and register bus response
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_ack          <= 1'b0;
            r_rdata        <= 32'd0;
            r_ntt_busy     <= 1'b0;
            r_ntt_done     <= 1'b0;
            r_ntt_err      <= 1'b0;
            r_ntt_mode     <= 1'b0;
            r_start_pend   <= 1'b0;
            r_ntt_start    <= 1'b0;
            r_cr_ioc_en    <= 1'b0;
            r_cr_err_en    <= 1'b0;
            r_sr_ioc       <= 1'b0;
            r_sr_slverr    <= 1'b0;
            r_sr_errirq    <= 1'b0;
            r_sa           <= 32'd0;
            r_da           <= 32'd0;
            r_btt          <= 23'd0;
            r_btt_ntt_busy <= 1'b0;
        end else begin
            r_ack        <= reg_req;
            r_rdata      <= 32'd0;
            r_start_pend <= 1'b0;
            // start is issued one cycle after the CTRL acknowledge
            r_ntt_start  <= r_start_pend;

            if (w_rd) begin
                if (w_hit_ctrl)      r_rdata <= {30'd0, r_ntt_mode, 1'b0};
                else if (w_hit_stat) r_rdata <= {29'd0, r_ntt_err, r_ntt_done, r_ntt_busy};
                else if (w_hit_cr)   r_rdata <= {17'd0, r_cr_err_en, 1'b0, r_cr_ioc_en, 12'd0};
                else if (w_hit_sr)   r_rdata <= {17'd0, r_sr_errirq, r_sr_slverr, r_sr_ioc,
                                                 10'd0, w_eng_idle, 1'b0};
                else if (w_hit_sa)   r_rdata <= r_sa;
                else if (w_hit_da)   r_rdata <= r_da;
                else if (w_hit_btt)  r_rdata <= {9'd0, r_btt};
                else if (w_hit_bram) r_rdata <= w_mem_rd_reg;
            end

            if (w_wr) begin
                if (w_hit_ctrl) begin
                    r_ntt_mode <= reg_wdata[1];
                    r_ntt_done <= 1'b0;
                    if (reg_wdata[0]) begin
                        if (r_ntt_busy) begin
                            r_ntt_err <= 1'b1;
                        end else begin
                            r_ntt_busy   <= 1'b1;
                            r_start_pend <= 1'b1;
                        end
                    end else begin
                        r_ntt_err <= 1'b0;
                    end
                end
                if (w_hit_cr) begin
                    if (reg_wdata[2]) begin
                        r_cr_ioc_en <= 1'b0;
                        r_cr_err_en <= 1'b0;
                        r_sr_ioc    <= 1'b0;
                        r_sr_slverr <= 1'b0;
                        r_sr_errirq <= 1'b0;
                        r_sa        <= 32'd0;
                        r_da        <= 32'd0;
                        r_btt       <= 23'd0;
                    end else begin
                        r_cr_ioc_en <= reg_wdata[12];
                        r_cr_err_en <= reg_wdata[14];
                    end
                end
                if (w_hit_sr) begin
                    if (reg_wdata[12]) r_sr_ioc    <= 1'b0;
                    if (reg_wdata[13]) r_sr_slverr <= 1'b0;
                    if (reg_wdata[14]) r_sr_errirq <= 1'b0;
                end
                if (w_hit_sa && w_eng_idle) r_sa <= reg_wdata;
                if (w_hit_da && w_eng_idle) r_da <= reg_wdata;
                if (w_hit_btt && w_eng_idle) begin
                    r_btt          <= reg_wdata[22:0];
                    r_btt_ntt_busy <= r_ntt_busy;
                end
            end

            // Event sets come after the bus writes so they win a same-cycle clear
            if (ntt_done) begin
                r_ntt_busy <= 1'b0;
                r_ntt_done <= 1'b1;
            end
            if (w_ioc_set) r_sr_ioc <= 1'b1;
            if (w_err_set) begin
                r_sr_slverr <= 1'b1;
                r_sr_errirq <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // BRAM: core owns the write port while busy, then engine, then bus
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK) begin
        if (r_ntt_busy) begin
            if (ntt_mem_en && ntt_mem_we) r_mem[ntt_mem_addr[c_AW-1:0]] <= ntt_mem_wdata;
        end else if (w_eng_mem_we) begin
            r_mem[win_idx(r_dst)] <= r_data;
        end else if (w_wr && w_hit_bram) begin
            r_mem[win_idx(reg_addr)] <= reg_wdata;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET)          ntt_mem_rdata <= 32'd0;
        else if (ntt_mem_en) ntt_mem_rdata <= r_mem[ntt_mem_addr[c_AW-1:0]];
    end

    assign reg_ack   = r_ack;
    assign reg_rdata = r_rdata;
    assign ntt_start = r_ntt_start;
    assign ntt_mode  = r_ntt_mode;
    assign irq       = {(r_sr_ioc & r_cr_ioc_en) | (r_sr_errirq & r_cr_err_en), r_ntt_done};

endmodule
`default_nettype wire

// File: tb/tb_ps_pl_platform_wrapper.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps_pl_platform_wrapper
// Purpose  : Self-checking bench for ps_pl_platform_wrapper with a DDR
//            responder, randomized data and a word-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps_pl_platform_wrapper;

    localparam logic [31:0] c_CTRL   = 32'h43C0_0000;
    localparam logic [31:0] c_STAT   = 32'h43C0_0004;
    localparam logic [31:0] c_DATA   = 32'h7600_0000;
    localparam logic [31:0] c_CR     = 32'h7E20_0000;
    localparam logic [31:0] c_SR     = 32'h7E20_0004;
    localparam logic [31:0] c_SA     = 32'h7E20_0018;
    localparam logic [31:0] c_DA     = 32'h7E20_0020;
    localparam logic [31:0] c_BTT    = 32'h7E20_0028;
    localparam logic [31:0] c_SRC    = 32'h0A00_0000;
    localparam logic [31:0] c_SR_IDLE = 32'h0000_0002;
    localparam logic [31:0] c_SR_IOC  = 32'h0000_1000;
    localparam logic [31:0] c_SR_ERR  = 32'h0000_6000;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_req, reg_we, reg_ack;
    logic [31:0] reg_addr, reg_wdata, reg_rdata;
    logic        ddr_req, ddr_we;
    logic [31:0] ddr_addr, ddr_wdata;
    logic        ddr_ack = 1'b0;
    logic [31:0] ddr_rdata = 32'd0;
    logic        ntt_start, ntt_mode, ntt_done;
    logic        ntt_mem_en, ntt_mem_we;
    logic [7:0]  ntt_mem_addr;
    logic [31:0] ntt_mem_wdata, ntt_mem_rdata;
    logic [1:0]  irq;

    ps_pl_platform_wrapper dut (
        .ACLK(clk), .ARESET(rst),
        .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_ack(reg_ack), .reg_rdata(reg_rdata),
        .ddr_req(ddr_req), .ddr_we(ddr_we), .ddr_addr(ddr_addr), .ddr_wdata(ddr_wdata),
        .ddr_ack(ddr_ack), .ddr_rdata(ddr_rdata),
        .ntt_start(ntt_start), .ntt_mode(ntt_mode), .ntt_done(ntt_done),
        .ntt_mem_en(ntt_mem_en), .ntt_mem_we(ntt_mem_we), .ntt_mem_addr(ntt_mem_addr),
        .ntt_mem_wdata(ntt_mem_wdata), .ntt_mem_rdata(ntt_mem_rdata),
        .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference state
    logic [31:0] ddr_m [logic [31:0]];
    logic [31:0] bram_m [256];
    logic [31:0] src_vals [256];
    int          ddr_wr_cnt = 0, ddr_rd_cnt = 0, start_cnt = 0;
    logic        last_start_mode = 1'b0;
    bit          fast_ack = 1'b1;
    int          n_cmp = 0, n_mis = 0;

    // DDR responder: ack decided at negedge, transaction committed at posedge
    always @(negedge clk) begin
        ddr_ack   = 1'b0;
        ddr_rdata = 32'd0;
        if (ddr_req && (fast_ack || $urandom_range(0, 2) == 0)) begin
            ddr_ack = 1'b1;
            if (!ddr_we && ddr_m.exists(ddr_addr)) ddr_rdata = ddr_m[ddr_addr];
        end
    end

    always @(posedge clk) begin
        if (ddr_req && ddr_ack) begin
            if (ddr_we) begin
                ddr_m[ddr_addr] = ddr_wdata;
                ddr_wr_cnt++;
            end else begin
                ddr_rd_cnt++;
            end
        end
        if (ntt_start) begin
            start_cnt++;
            last_start_mode = ntt_mode;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata);
        @(negedge clk);
        reg_req = 1'b1; reg_we = we; reg_addr = addr; reg_wdata = wdata;
        @(negedge clk);
        reg_req = 1'b0; reg_we = 1'b0;
        rdata = reg_rdata;
        chk("reg_ack", {31'd0, reg_ack}, 32'd1);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] dummy;
        bus(1'b1, addr, data, dummy);
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        bus(1'b0, addr, 32'd0, data);
    endtask

    // Counts negedges until irq[1] rises; an expired budget is a failure
    task automatic wait_irq1(input int budget, output int cycles);
        cycles = 0;
        while (irq[1] !== 1'b1 && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        if (irq[1] !== 1'b1) chk("irq1_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d, v;
        int          cyc, bad, snap_w, snap_r, a, s, t;
        logic [31:0] e_sa  [3];
        logic [31:0] e_btt [3];

        e_sa  = '{c_SRC, c_SRC, c_DATA + 32'h3F0};
        e_btt = '{32'd1022, 32'd0, 32'd32};

        rst = 1'b1;
        reg_req = 1'b0; reg_we = 1'b0; reg_addr = 32'd0; reg_wdata = 32'd0;
        ntt_done = 1'b0; ntt_mem_en = 1'b0; ntt_mem_we = 1'b0;
        ntt_mem_addr = 8'd0; ntt_mem_wdata = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // ---------------- reset state ----------------
        chk("rst_irq", {30'd0, irq}, 32'd0);
        chk("rst_ddr_req", {31'd0, ddr_req}, 32'd0);
        chk("rst_ntt_start", {31'd0, ntt_start}, 32'd0);
        chk("rst_ntt_rdata", ntt_mem_rdata, 32'd0);
        rd(c_SR, d);   chk("rst_sr", d, c_SR_IDLE);
        rd(c_STAT, d); chk("rst_status", d, 32'd0);
        rd(c_SA, d);   chk("rst_sa", d, 32'd0);

        // ---------------- DDR -> BRAM, immediate ack ----------------
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            ddr_m[c_SRC + 32'(4 * i)] = v;
            src_vals[i] = v;
        end
        fast_ack = 1'b1;
        wr(c_CR, 32'h1000);
        wr(c_SA, c_SRC);
        wr(c_DA, c_DATA);
        wr(c_BTT, 32'd1024);
        wait_irq1(2000, cyc);
        chk("d2b_latency", 32'(cyc), 32'(2 * 256 + 1));
        for (int i = 0; i < 256; i++) bram_m[i] = src_vals[i];
        rd(c_SR, d); chk("d2b_sr", d, c_SR_IOC | c_SR_IDLE);
        rd(c_DATA + 32'd1020, d); chk("d2b_word255", d, bram_m[255]);
        for (int k = 0; k < 3; k++) begin
            a = $urandom_range(0, 254);
            rd(c_DATA + 32'(4 * a), d); chk("d2b_word_rand", d, bram_m[a]);
        end
        wr(c_SR, 32'hF000);
        chk("w1c_irq1", {31'd0, irq[1]}, 32'd0);
        rd(c_SR, d); chk("w1c_sr", d, c_SR_IDLE);

        // ---------------- NTT start / busy / done ----------------
        wr(c_CTRL, 32'h3);
        @(negedge clk);
        chk("start_timing", {31'd0, ntt_start}, 32'd1);
        chk("start_mode", {31'd0, ntt_mode}, 32'd1);
        rd(c_STAT, d); chk("status_busy", d, 32'd1);
        wr(c_CTRL, 32'h3);
        rd(c_STAT, d); chk("status_busy_err", d, 32'd5);

        // BTT while NTT busy must error without DDR traffic
        wr(c_SA, c_SRC);
        wr(c_DA, 32'h0C00_0000);
        snap_w = ddr_wr_cnt; snap_r = ddr_rd_cnt;
        wr(c_BTT, 32'd16);
        repeat (4) @(negedge clk);
        rd(c_SR, d); chk("btt_ntt_busy_sr", d, c_SR_ERR | c_SR_IDLE);
        chk("btt_ntt_busy_traffic", 32'((ddr_wr_cnt - snap_w) + (ddr_rd_cnt - snap_r)), 32'd0);
        wr(c_SR, 32'hF000);

        // Core writes the BRAM while it owns it
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            a = $urandom_range(0, 255);
            v = $urandom;
            ntt_mem_en = 1'b1; ntt_mem_we = 1'b1;
            ntt_mem_addr = 8'(a); ntt_mem_wdata = v;
            bram_m[a] = v;
        end
        @(negedge clk);
        ntt_mem_en = 1'b0; ntt_mem_we = 1'b0;
        // Bus write while busy is dropped
        a = $urandom_range(0, 255);
        wr(c_DATA + 32'(4 * a), ~bram_m[a]);
        @(negedge clk);
        ntt_mem_en = 1'b1; ntt_mem_addr = 8'(a);
        @(negedge clk);
        ntt_mem_en = 1'b0;
        chk("ntt_mem_read", ntt_mem_rdata, bram_m[a]);
        rd(c_DATA + 32'(4 * a), d); chk("bus_write_dropped", d, bram_m[a]);

        @(negedge clk); ntt_done = 1'b1;
        @(negedge clk); ntt_done = 1'b0;
        chk("irq0_after_done", {31'd0, irq[0]}, 32'd1);
        rd(c_STAT, d); chk("status_done_err", d, 32'd6);
        wr(c_CTRL, 32'h2);
        chk("irq0_cleared", {31'd0, irq[0]}, 32'd0);
        rd(c_STAT, d); chk("status_cleared", d, 32'd0);
        rd(c_CTRL, d); chk("ctrl_readback", d, 32'd2);
        chk("start_count1", 32'(start_cnt), 32'd1);
        chk("start_mode_seen", {31'd0, last_start_mode}, 32'd1);

        // ntt_done coincident with a CTRL write: done survives
        wr(c_CTRL, 32'h1);
        repeat (3) @(negedge clk);
        @(negedge clk);
        reg_req = 1'b1; reg_we = 1'b1; reg_addr = c_CTRL; reg_wdata = 32'd0; ntt_done = 1'b1;
        @(negedge clk);
        reg_req = 1'b0; reg_we = 1'b0; ntt_done = 1'b0;
        rd(c_STAT, d); chk("done_vs_ctrl", d, 32'd2);
        chk("done_vs_ctrl_irq0", {31'd0, irq[0]}, 32'd1);
        chk("start_count2", 32'(start_cnt), 32'd2);
        wr(c_CTRL, 32'h0);

        // ---------------- BRAM -> DDR, random ack delay ----------------
        fast_ack = 1'b0;
        wr(c_SA, c_DATA);
        wr(c_DA, 32'h0B00_0000);
        wr(c_BTT, 32'd1024);
        wait_irq1(10000, cyc);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (!ddr_m.exists(32'h0B00_0000 + 32'(4 * i))) bad++;
            else if (ddr_m[32'h0B00_0000 + 32'(4 * i)] !== bram_m[i]) bad++;
        end
        chk("b2d_bad_words", 32'(bad), 32'd0);
        rd(c_SR, d); chk("b2d_sr", d, c_SR_IOC | c_SR_IDLE);
        wr(c_SR, 32'hF000);

        // ---------------- error causes ----------------
        wr(c_CR, 32'h5000);
        for (int k = 0; k < 3; k++) begin
            wr(c_SA, e_sa[k]);
            wr(c_DA, 32'h0C00_0000);
            snap_w = ddr_wr_cnt; snap_r = ddr_rd_cnt;
            wr(c_BTT, e_btt[k]);
            repeat (4) @(negedge clk);
            chk("err_irq1", {31'd0, irq[1]}, 32'd1);
            rd(c_SR, d); chk("err_sr", d, c_SR_ERR | c_SR_IDLE);
            chk("err_traffic", 32'((ddr_wr_cnt - snap_w) + (ddr_rd_cnt - snap_r)), 32'd0);
            wr(c_SR, 32'hF000);
        end

        // Exactly reaching the end of the window is legal
        wr(c_SA, c_DATA + 32'h3E0);
        wr(c_DA, 32'h0D00_0000);
        wr(c_BTT, 32'd32);
        wait_irq1(500, cyc);
        bad = 0;
        for (int i = 0; i < 8; i++)
            if (ddr_m[32'h0D00_0000 + 32'(4 * i)] !== bram_m[248 + i]) bad++;
        chk("edge_bad_words", 32'(bad), 32'd0);
        rd(c_SR, d); chk("edge_sr", d, c_SR_IOC | c_SR_IDLE);
        wr(c_SR, 32'hF000);

        // ---------------- BRAM -> BRAM, W1C colliding with IOC set ----------------
        s = $urandom_range(0, 127);
        t = $urandom_range(128, 255);
        wr(c_SA, c_DATA + 32'(4 * s));
        wr(c_DA, c_DATA + 32'(4 * t));
        @(negedge clk);
        reg_req = 1'b1; reg_we = 1'b1; reg_addr = c_BTT; reg_wdata = 32'd4;
        @(negedge clk); reg_req = 1'b0; reg_we = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reg_req = 1'b1; reg_we = 1'b1; reg_addr = c_SR; reg_wdata = 32'hF000;
        @(negedge clk); reg_req = 1'b0; reg_we = 1'b0;
        bram_m[t] = bram_m[s];
        rd(c_SR, d); chk("set_wins_sr", d, c_SR_IOC | c_SR_IDLE);
        rd(c_DATA + 32'(4 * t), d); chk("b2b_word", d, bram_m[t]);
        wr(c_SR, 32'hF000);

        // ---------------- soft reset mid-transfer ----------------
        for (int i = 0; i < 100; i++) ddr_m[c_SRC + 32'(4 * i)] = $urandom;
        wr(c_SA, c_SRC);
        wr(c_DA, 32'h0E00_0000);
        wr(c_BTT, 32'd400);
        repeat (30) @(negedge clk);
        wr(c_CR, 32'h4);
        chk("srst_ddr_req", {31'd0, ddr_req}, 32'd0);
        snap_w = ddr_wr_cnt;
        repeat (20) @(negedge clk);
        chk("srst_no_writes", 32'(ddr_wr_cnt - snap_w), 32'd0);
        rd(c_SR, d);  chk("srst_sr", d, c_SR_IDLE);
        rd(c_SA, d);  chk("srst_sa", d, 32'd0);
        rd(c_BTT, d); chk("srst_btt", d, 32'd0);
        rd(c_CR, d);  chk("srst_cr", d, 32'd0);
        rd(32'h1234_5670, d); chk("unmapped_read", d, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps_pl_platform_wrapper.md
# ps_pl_platform_wrapper

PL-side platform block that connects the processor register bus to a CDMA-style copy engine, a 256 x 32-bit local coefficient BRAM and the control/status registers of an external NTT core. Software loads coefficients from DDR into the BRAM, starts an NTT or iNTT, waits for the done interrupt, then copies the result back to DDR. The block has two interrupt lines: line 0 is NTT done and line 1 is CDMA.

## Interface
Parameters:
- NTT_SIZE, 256: number of BRAM words.
- NTT_CTRL_BASE, 32'h43C0_0000: base address of the NTT register window.
- NTT_DATA_BASE, 32'h7600_0000: base address of the BRAM window, which is NTT_SIZE*4 bytes long.
- CDMA_BASE, 32'h7E20_0000: base address of the CDMA register window.

Ports:
- ACLK  in  1  single clock.
- ARESET  in  1  asynchronous reset, active-high.
- reg_req  in  1  register bus request, one-cycle pulse.
- reg_we  in  1  1 = write, 0 = read.
- reg_addr  in  32  byte address.
- reg_wdata  in  32  write data.
- reg_ack  out  1  one-cycle acknowledge.
- reg_rdata  out  32  read data, valid while reg_ack is high.
- ddr_req  out  1  DDR word request, held until acknowledged.
- ddr_we  out  1  DDR write enable.
- ddr_addr  out  32  DDR byte address.
- ddr_wdata  out  32  DDR write data.
- ddr_ack  in  1  DDR acknowledge; ddr_rdata is valid in the same cycle.
- ddr_rdata  in  32  DDR read data.
- ntt_start  out  1  one-cycle start pulse to the NTT core.
- ntt_mode  out  1  0 = NTT, 1 = iNTT.
- ntt_done  in  1  one-cycle done pulse from the NTT core.
- ntt_mem_en  in  1  NTT core BRAM enable.
- ntt_mem_we  in  1  NTT core BRAM write enable.
- ntt_mem_addr  in  8  NTT core BRAM word address.
- ntt_mem_wdata  in  32  NTT core BRAM write data.
- ntt_mem_rdata  out  32  NTT core BRAM read data, one cycle after ntt_mem_en.
- irq  out  2  irq[0] = NTT done, irq[1] = CDMA.

## Operation
NTT register window:
- CTRL at offset 0x00:
  - bit0 is START. Writing 1 while not busy pulses ntt_start and sets busy. Writing 1 while busy sets STATUS.err and does not pulse ntt_start.
  - bit1 is MODE and drives ntt_mode.
  - Any write to CTRL clears the done flag.
  - Reads return {30'b0, MODE, 1'b0}.
- STATUS at offset 0x04 is read-only: bit0 busy, bit1 done, bit2 err. The err bit is cleared by a write to CTRL with START=0.
- On ntt_done, busy clears and done sets. irq[0] equals the done flag.

CDMA register window:
- CR at offset 0x00:
  - bit2 RESET: writing 1 performs a soft reset. The soft reset aborts any transfer, clears SA, DA, BTT, SR flags and CR, and leaves the engine idle. The bit self-clears.
  - bit12 IOC_IrqEn.
  - bit14 Err_IrqEn.
- SR at offset 0x04:
  - bit1 Idle.
  - bit12 IOC_Irq.
  - bit13 DMASlvErr.
  - bit14 Err_Irq.
  - Bits 15:12 are write-1-to-clear.
- SA at 0x18, DA at 0x20, BTT at 0x28. BTT uses bits 22:0.
- Writing BTT starts a transfer.
- Writes to SA, DA or BTT while the engine is busy are ignored.
- irq[1] = (IOC_Irq & IOC_IrqEn) | (Err_Irq & Err_IrqEn).

Reads and writes on the register bus:
- Unmapped reads return 0; unmapped writes are ignored.
- Reads from the BRAM window return the BRAM word; writes to the BRAM window store the word.

Transfer behaviour:
- An address inside the BRAM window maps to BRAM word (addr - NTT_DATA_BASE) >> 2. Any other address goes to DDR.
- The engine copies BTT/4 words in order, incrementing both addresses by 4 per word.
- Errors set DMASlvErr and Err_Irq, leave IOC clear and return the engine to idle. Error causes:
  - BTT = 0;
  - BTT[1:0] != 0;
  - a BRAM-window transfer that would run past the end of the window;
  - BTT written while NTT is busy.
  These are checked before the first word.
- Successful completion sets IOC_Irq.

Engine FSM:
- IDLE -> CHECK on a BTT write.
- CHECK -> ERR or RD.
- RD: DDR read (wait for ddr_ack) or BRAM read (1 cycle), then -> WR.
- WR: DDR write (wait for ddr_ack) or BRAM write, then -> RD if words remain, otherwise -> DONE.
- DONE and ERR -> IDLE.

BRAM arbitration:
- While NTT is busy, the NTT core owns the BRAM port.
- Otherwise the CDMA engine owns it, then register-bus accesses.
- Register-bus BRAM writes while NTT is busy are dropped.

## Timing
- On reset, all outputs are 0, all registers are 0 and SR reads 0x0000_0002.
- reg_ack is asserted exactly 1 cycle after reg_req.
- ntt_start pulses in the cycle after the CTRL write acknowledge.
- The done flag and irq[0] rise 1 cycle after ntt_done.
- For a BRAM-to-DDR or DDR-to-BRAM copy with ddr_ack returned immediately, each word takes 2 cycles plus the DDR wait. IOC is set 1 cycle after the last write.
- ntt_done and a CTRL write in the same cycle: done is set and the clear is lost, so done ends at 1.
- W1C write to SR and IOC set in the same cycle: the set wins.
- Soft reset in the middle of a transfer: ddr_req drops the next cycle and no further writes occur.

## Test plan
- Reset, then read CDMA SR -> 0x0000_0002. Read NTT STATUS -> 0.
- Preload DDR at 0x0A00_0000 with 256 words. Write CR=0x1000, SA=0x0A00_0000, DA=0x7600_0000, BTT=1024 -> irq[1] rises and SR=0x0000_1002. Read BRAM word 255 through the register bus -> matches DDR. W1C 0xF000 to SR -> irq[1]=0.
- Write CTRL=0x3 -> ntt_start pulses once with ntt_mode=1 and STATUS=1. Core pulses ntt_done -> irq[0]=1 and STATUS=2. Write CTRL=0 -> irq[0]=0.
- Copy BRAM to DDR with BTT=1024 -> all 256 DDR words equal the BRAM contents and irq[1] rises.
- BTT=1022, then a BTT write while NTT is busy -> each gives SR bit13 and bit14 set, no DDR traffic and IOC=0.
- Soft reset (CR=0x4) in the middle of a transfer -> engine idle, SR=0x0000_0002, ddr_req=0.
